// File: rtl/serial_rx_port_pkg.sv
// Shared types and helpers for the serial bus receive port.
// Provides FSM states, request-mode encodings and beat-count arithmetic.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Number of beats needed to move `width` bits over `lanes` wires.
    function automatic int beats(input int width, input int lanes);
        return (width + lanes - 1) / lanes;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_rx_port_lane_deserializer.sv
// Shadow register filled LANES bits per beat (LSB first), committed to a
// held output only when the whole request has arrived.
module lane_deserializer #(
    parameter int WIDTH  = 12,
    parameter int LANES  = 1,
    parameter int BEAT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              commit_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [LANES-1:0]  lanes_i,
    output logic [WIDTH-1:0]  value_o
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] lane_vec;
    logic [WIDTH-1:0] lane_mask;
    int               shift_amt;

    // Beats that land past the field width shift completely out and are dropped.
    always_comb begin
        shift_amt = int'(beat_i) * LANES;
        lane_vec  = WIDTH'(lanes_i) << shift_amt;
        lane_mask = WIDTH'({LANES{1'b1}}) << shift_amt;
        shadow_d  = clear_i ? '0 : shadow_q;
        if (load_i) begin
            shadow_d = (shadow_d & ~lane_mask) | lane_vec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            value_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (commit_i) begin
                value_q <= shadow_d;
            end
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/serial_rx_port.sv
// Receive port: deserialises mode/address/write-data requests from the serial
// bus and holds the completed request until downstream acknowledges it.
module serial_rx_port
    import serial_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      rx_address,
    input  logic [LANES-1:0]      rx_data,
    input  logic                  master_valid,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic                  rx_ack,
    output logic                  slave_ready,
    output logic                  rx_done,
    output logic                  rx_abort,
    output logic                  rx_is_write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int ADDR_BEATS = beats(ADDR_WIDTH, LANES);
    localparam int DATA_BEATS = beats(DATA_WIDTH, LANES);
    localparam int LEN_RD     = ADDR_BEATS;
    localparam int LEN_WR     = max_int(ADDR_BEATS, DATA_BEATS);
    localparam int CNT_W      = $clog2(max_int(LEN_RD, LEN_WR) + 1);

    localparam logic [CNT_W-1:0] LEN_RD_C = CNT_W'(LEN_RD);
    localparam logic [CNT_W-1:0] LEN_WR_C = CNT_W'(LEN_WR);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             slave_ready_q;
    logic             rx_done_q;
    logic             rx_abort_q;
    logic             rx_is_write_q;

    logic             start;
    logic             capture;
    logic             last_beat;
    logic             cur_write;
    logic [CNT_W-1:0] beat_idx;
    logic [CNT_W-1:0] req_len;

    // Decode which beat (if any) is captured this edge and whether it completes the request.
    always_comb begin
        start     = 1'b0;
        capture   = 1'b0;
        cur_write = mode_q;
        beat_idx  = '0;
        case (state_q)
            IDLE: begin
                if (master_valid && (read_en ^ write_en)) begin
                    start     = 1'b1;
                    capture   = 1'b1;
                    cur_write = write_en ? MODE_WRITE : MODE_READ;
                end
            end
            RECV: begin
                if (master_valid) begin
                    capture  = 1'b1;
                    beat_idx = cnt_q;
                end
            end
            default: begin
                capture = 1'b0;
            end
        endcase
        req_len   = (cur_write == MODE_WRITE) ? LEN_WR_C : LEN_RD_C;
        last_beat = capture && ((beat_idx + CNT_W'(1)) == req_len);
    end

    lane_deserializer #(
        .WIDTH  (ADDR_WIDTH),
        .LANES  (LANES),
        .BEAT_W (CNT_W)
    ) u_addr_des (
        .clk_i    (clk),
        .rst_ni   (reset),
        .load_i   (capture),
        .clear_i  (start),
        .commit_i (last_beat),
        .beat_i   (beat_idx),
        .lanes_i  (rx_address),
        .value_o  (address)
    );

    // Reads never load the data shadow, so the clear on start commits as zero.
    lane_deserializer #(
        .WIDTH  (DATA_WIDTH),
        .LANES  (LANES),
        .BEAT_W (CNT_W)
    ) u_data_des (
        .clk_i    (clk),
        .rst_ni   (reset),
        .load_i   (capture && (cur_write == MODE_WRITE)),
        .clear_i  (start),
        .commit_i (last_beat),
        .beat_i   (beat_idx),
        .lanes_i  (rx_data),
        .value_o  (data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mode_q        <= MODE_READ;
            slave_ready_q <= 1'b0;
            rx_done_q     <= 1'b0;
            rx_abort_q    <= 1'b0;
            rx_is_write_q <= 1'b0;
        end else begin
            rx_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    slave_ready_q <= 1'b1;
                    rx_done_q     <= 1'b0;
                    if (start) begin
                        mode_q <= cur_write;
                        cnt_q  <= CNT_W'(1);
                        if (last_beat) begin
                            state_q       <= DONE;
                            rx_done_q     <= 1'b1;
                            slave_ready_q <= 1'b0;
                            rx_is_write_q <= cur_write;
                        end else begin
                            state_q <= RECV;
                        end
                    end else if (master_valid) begin
                        rx_abort_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (master_valid) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q       <= DONE;
                            rx_done_q     <= 1'b1;
                            slave_ready_q <= 1'b0;
                            rx_is_write_q <= mode_q;
                        end
                    end else begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        rx_abort_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (rx_ack) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        rx_done_q     <= 1'b0;
                        slave_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    slave_ready_q <= 1'b1;
                    rx_done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign slave_ready = slave_ready_q;
    assign rx_done     = rx_done_q;
    assign rx_abort    = rx_abort_q;
    assign rx_is_write = rx_is_write_q;

endmodule
